// File: rtl/telemetry_conditioner_if.sv
// Raw-frame input and conditioned-frame output bundle of telemetry_conditioner.
// The master side is the frame producer/consumer; the conditioner uses slave.
interface telemetry_conditioner_if;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] raw_altitude;
    logic       raw_temp;
    logic       raw_rad;
    logic       raw_oxygen;
    logic       raw_life;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] altitude;
    logic       temp;
    logic       rad;
    logic       oxygen;
    logic       life;
    logic       fill_done;
    logic       stale;

    modport master (
        output in_valid, raw_altitude, raw_temp, raw_rad, raw_oxygen, raw_life, out_ready,
        input  in_ready, out_valid, altitude, temp, rad, oxygen, life, fill_done, stale
    );

    modport slave (
        input  in_valid, raw_altitude, raw_temp, raw_rad, raw_oxygen, raw_life, out_ready,
        output in_ready, out_valid, altitude, temp, rad, oxygen, life, fill_done, stale
    );
endinterface

// File: rtl/telemetry_conditioner.sv
// Sensor front end: moving-average altitude, per-flag debounce, one output frame per accept.
// Optional idle watchdog enabled by defining STALE_TIMEOUT_EN.
//
// state  | meaning
// S_FILL | collecting the first WINDOW samples, no output frames
// S_RUN  | window full, every accept produces a frame one cycle later
module telemetry_conditioner #(
    parameter int AVG_LOG2    = 2,
    parameter int DEB_COUNT   = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    telemetry_conditioner_if.slave  bus
);
    localparam int WINDOW = 1 << AVG_LOG2;
    localparam int SUM_W  = 10 + AVG_LOG2;
    localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2 + 1)'(WINDOW - 1);
    localparam logic [2:0]        DEB_LAST  = 3'(DEB_COUNT - 1);

    if (AVG_LOG2 < 1 || AVG_LOG2 > 4 || DEB_COUNT < 1 || DEB_COUNT > 7 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("telemetry_conditioner: parameter out of legal range");
    end

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t              state, state_next;
    logic [9:0]          win [WINDOW];
    logic [AVG_LOG2-1:0] ptr;
    logic [SUM_W-1:0]    sum, sum_next;
    logic [AVG_LOG2:0]   fill_cnt;
    logic [2:0]          deb_cnt [4];
    logic [3:0]          raw_flags, flags;
    logic [9:0]          altitude_q;
    logic                out_valid_q, in_ready, accept, clear, frame_load, stale_hit;

    assign in_ready  = !flush && (!out_valid_q || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign clear     = flush || stale_hit;
    assign raw_flags = {bus.raw_life, bus.raw_oxygen, bus.raw_rad, bus.raw_temp};
    assign sum_next  = sum - {{AVG_LOG2{1'b0}}, win[ptr]} + {{AVG_LOG2{1'b0}}, bus.raw_altitude};

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.altitude  = altitude_q;
    assign bus.temp      = flags[0];
    assign bus.rad       = flags[1];
    assign bus.oxygen    = flags[2];
    assign bus.life      = flags[3];
    assign bus.fill_done = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) state <= S_FILL;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        frame_load = 1'b0;
        if (clear) begin
            state_next = S_FILL;
        end else if (accept) begin
            case (state)
                S_FILL: if (fill_cnt == FILL_LAST) begin
                    state_next = S_RUN;
                    frame_load = 1'b1;
                end
                S_RUN:  frame_load = 1'b1;
                default: state_next = S_FILL;
            endcase
        end
    end

    // Altitude register is deliberately left untouched by flush.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < WINDOW; i++) win[i] <= '0;
            ptr         <= '0;
            sum         <= '0;
            fill_cnt    <= '0;
            out_valid_q <= 1'b0;
            if (rst) altitude_q <= '0;
        end else begin
            if (accept) begin
                win[ptr] <= bus.raw_altitude;
                ptr      <= ptr + 1'b1;
                sum      <= sum_next;
                if (state == S_FILL) fill_cnt <= fill_cnt + 1'b1;
            end
            if (frame_load) begin
                out_valid_q <= 1'b1;
                altitude_q  <= sum_next[SUM_W-1:AVG_LOG2];
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                flags[i]   <= 1'b0;
                deb_cnt[i] <= '0;
            end else if (clear) begin
                deb_cnt[i] <= '0;
            end else if (accept) begin
                if (raw_flags[i] == flags[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    flags[i]   <= ~flags[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef STALE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              stale_q;

    // Fires on the edge where the counter reaches TIMEOUT_CYC; saturation stops repeats.
    assign stale_hit = !accept && (idle_cnt == IDLE_LAST);
    assign bus.stale = stale_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
            stale_q  <= 1'b0;
        end else if (flush) begin
            idle_cnt <= '0;
        end else if (accept) begin
            idle_cnt <= '0;
            stale_q  <= 1'b0;
        end else begin
            if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
            if (stale_hit)            stale_q  <= 1'b1;
        end
    end
`else
    assign stale_hit = 1'b0;
    assign bus.stale = 1'b0;
`endif
endmodule

// File: tb/tb_telemetry_conditioner.sv
// Directed self-checking bench for telemetry_conditioner with hand-computed expectations.
module tb_telemetry_conditioner;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   total = 0;
    int   bad   = 0;

    telemetry_conditioner_if bus ();

    telemetry_conditioner #(
        .AVG_LOG2    (2),
        .DEB_COUNT   (3),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one frame at the falling edge, wait (bounded) for in_ready, sample 1ns after the accept edge.
    task automatic send(input logic [9:0] alt, input logic t, input logic r, input logic o, input logic l);
        int n;
        @(negedge clk);
        bus.raw_altitude = alt;
        bus.raw_temp     = t;
        bus.raw_rad      = r;
        bus.raw_oxygen   = o;
        bus.raw_life     = l;
        bus.in_valid     = 1'b1;
        #1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("send_timeout", 16'(n), 16'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        flush            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b1;
        bus.raw_altitude = '0;
        bus.raw_temp     = 1'b0;
        bus.raw_rad      = 1'b0;
        bus.raw_oxygen   = 1'b0;
        bus.raw_life     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_altitude",  bus.altitude,  0);
        chk("rst_temp",      bus.temp,      0);
        chk("rst_fill_done", bus.fill_done, 0);
        chk("rst_stale",     bus.stale,     0);
        chk("rst_in_ready",  bus.in_ready,  1);

        // Fill then run: averages of the last four samples
        send(100, 0, 0, 0, 0); chk("fill1_valid", bus.out_valid, 0);
        send(200, 0, 0, 0, 0); chk("fill2_valid", bus.out_valid, 0);
        send(300, 0, 0, 0, 0); chk("fill3_valid", bus.out_valid, 0);
        send(400, 0, 0, 0, 0);
        chk("first_valid", bus.out_valid, 1);
        chk("first_alt",   bus.altitude,  250);
        chk("first_fill",  bus.fill_done, 1);
        send(800,  0, 0, 0, 0); chk("alt_800",  bus.altitude, 425);
        send(1023, 0, 0, 0, 0); chk("alt_1023a", bus.altitude, 630);
        send(1023, 0, 0, 0, 0); chk("alt_1023b", bus.altitude, 811);
        send(1023, 0, 0, 0, 0); chk("alt_1023c", bus.altitude, 967);
        send(1023, 0, 0, 0, 0); chk("alt_1023d", bus.altitude, 1023);

        // Debounce: two highs then a low do not flip; three highs do
        send(1023, 1, 0, 0, 0); chk("deb_t1", bus.temp, 0);
        send(1023, 1, 0, 0, 0); chk("deb_t2", bus.temp, 0);
        send(1023, 0, 0, 0, 0); chk("deb_back", bus.temp, 0);
        send(1023, 1, 0, 0, 0); chk("deb_h1", bus.temp, 0);
        send(1023, 1, 0, 0, 0); chk("deb_h2", bus.temp, 0);
        send(1023, 1, 0, 0, 0);
        chk("deb_h3",     bus.temp,     1);
        chk("deb_rad",    bus.rad,      0);
        chk("deb_oxygen", bus.oxygen,   0);
        chk("deb_life",   bus.life,     0);
        chk("deb_alt",    bus.altitude, 1023);

        // Backpressure: output held, no accept while out_ready is low
        @(negedge clk);
        bus.out_ready    = 1'b0;
        bus.raw_altitude = 10'd0;
        bus.raw_temp     = 1'b1;
        bus.in_valid     = 1'b1;
        #1;
        chk("bp_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_alt", bus.altitude, 1023);
        end
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_hold_temp",  bus.temp,      1);
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp_new_valid", bus.out_valid, 1);
        chk("bp_new_alt",   bus.altitude,  767);
        @(posedge clk);
        #1;
        chk("bp_consumed", bus.out_valid, 0);

        // Reset in the middle of FILL discards the partial window
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(500, 0, 0, 0, 0);
        send(500, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_alt",   bus.altitude,  0);
        chk("mid_rst_temp",  bus.temp,      0);
        chk("mid_rst_fill",  bus.fill_done, 0);
        send(40,  0, 1, 0, 0); chk("refill1", bus.out_valid, 0);
        send(80,  0, 1, 0, 0); chk("refill2", bus.out_valid, 0);
        send(120, 0, 1, 0, 0); chk("refill3", bus.out_valid, 0);
        send(160, 0, 1, 0, 0);
        chk("refill_valid", bus.out_valid, 1);
        chk("refill_alt",   bus.altitude,  100);
        chk("refill_rad",   bus.rad,       1);

        // Flush in RUN: frame presented during flush is refused, flags and altitude kept
        @(negedge clk);
        flush            = 1'b1;
        bus.raw_altitude = 10'd1000;
        bus.raw_rad      = 1'b1;
        bus.in_valid     = 1'b1;
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        chk("flush_fill",  bus.fill_done, 0);
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_rad",   bus.rad,       1);
        chk("flush_alt",   bus.altitude,  100);
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        send(8, 0, 1, 0, 0); chk("postflush1", bus.out_valid, 0);
        send(8, 0, 1, 0, 0); chk("postflush2", bus.out_valid, 0);
        send(8, 0, 1, 0, 0); chk("postflush3", bus.out_valid, 0);
        send(8, 0, 1, 0, 0);
        chk("postflush_valid", bus.out_valid, 1);
        chk("postflush_alt",   bus.altitude,  8);

        // Idle watchdog
        repeat (25) @(posedge clk);
        #1;
`ifdef STALE_TIMEOUT_EN
        chk("stale_set",   bus.stale,     1);
        chk("stale_fill",  bus.fill_done, 0);
        chk("stale_valid", bus.out_valid, 0);
        send(5, 0, 1, 0, 0);
        chk("stale_clear",      bus.stale,     0);
        chk("stale_still_fill", bus.fill_done, 0);
`else
        chk("stale_tied", bus.stale,     0);
        chk("idle_run",   bus.fill_done, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
